csa_wordserial_adder: RTL and testbench
=======================================

// Module: csa_wordserial_adder
// PURPOSE
//  Word-serial multi-precision adder that sits upstream of one adderblock16bit
//  instance, which it instantiates and drives.
//  - Accepts WORDS x 16-bit operand slices, least-significant first, over a
//    valid/ready stream.
//  - Feeds each slice plus the running carry into the conditional-sum adder.
//  - Registers the 16-bit result and returns it downstream with the final carry.
//  - Gives the 16-bit CSA datapath arbitrary-width additions (default 64-bit).
// PARAMETERS
//  WORDS  4  16-bit slices per transaction; legal range 1..256.
// PORTS
//  clk        in   1   single clock; all state updates on the rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operand slice valid
//  in_ready   out  1   slice accepted when in_valid && in_ready
//  a_word     in   16  operand A slice
//  b_word     in   16  operand B slice
//  cin        in   1   carry-in; sampled only on slice 0 of a transaction
//  out_valid  out  1   result slice valid
//  out_ready  in   1   downstream accepts when out_valid && out_ready
//  sum_word   out  16  result slice (adder sum[15:0])
//  out_last   out  1   high with the final slice (index WORDS-1)
//  cout       out  1   carry-out of the final slice; meaningful only when out_last=1
// BEHAVIOUR
//  - Reset values: out_valid=0, sum_word=0, out_last=0, cout=0, slice counter=0,
//    carry register=0. in_ready=1 after reset.
//  - in_ready = !out_valid || out_ready. There is one output register, no skid
//    buffer, and no combinational path from in_valid to out_valid.
//  - On accept:
//    - Adder carry input = (cnt==0) ? cin : carry_reg.
//    - sum_word <= sum[15:0]; carry_reg <= sum[16]; out_valid <= 1.
//    - out_last <= (cnt==WORDS-1); cout <= sum[16].
//    - cnt <= (cnt==WORDS-1) ? 0 : cnt+1.
//  - Latency: exactly 1 cycle from accept to out_valid. Throughput: 1 slice per
//    cycle while out_ready=1.
//  - Output handshake with no new accept that cycle: out_valid <= 0.
//  - Simultaneous output handshake and new accept: the new slice replaces the
//    output register and out_valid stays 1.
//  - Stall (out_valid && !out_ready): all outputs, cnt and carry_reg hold
//    unchanged.
//  - Counter wrap: after slice WORDS-1, cnt returns to 0. The next slice starts
//    a new transaction and uses cin; carry never leaks between transactions.
//  - WORDS=1: every slice is both first and last; out_last=1 on every result.
//  - rst mid-transaction: the partial transaction is discarded (out_valid=0,
//    cnt=0, carry=0). The next accepted slice is slice 0.
//  - Sums are modulo 2^16 per slice. The full-width result is the concatenation
//    of the slices plus cout.
//  - FSM: IDLE (cnt=0) -> ACCUM (0<cnt<WORDS) on accept; ACCUM -> IDLE on accept
//    of slice WORDS-1; any state -> IDLE on rst.
// CONFIGURATION
//  CSA_SIGNED_OVF_EN defined:
//   - Adds output port ovf (1 bit, reset 0).
//   - ovf is registered with each slice as out_last &&
//     (a_word[15]==b_word[15]) && (sum[15]!=a_word[15]).
//   - This is two's-complement overflow of the full-width add; ovf is 0 on all
//     non-final slices.
//  CSA_SIGNED_OVF_EN undefined:
//   - Port ovf and its logic are absent; all other behaviour is identical.
// TESTING (WORDS=4 unless stated)
//  1. A=FFFF,FFFF,FFFF,FFFF; B=0001,0000,0000,0000; cin=0; out_ready=1
//     -> sum_word=0000 x4, out_last only on 4th slice, cout=1.
//  2. A=00CD,0,0,0; B=00FC,0,0,0; cin=1
//     -> sum_word=01CA,0000,0000,0000; cout=0.
//  3. Case 1 with out_ready=0 for 3 cycles after first result
//     -> in_ready=0 and sum_word/out_valid held for 3 cycles; resumes with
//        no slice lost or duplicated.
//  4. Assert rst after 2 slices accepted, then send A=0001,.. B=0001,.. cin=1
//     -> out_valid=0 the cycle after rst; next result slice=0003, treated as
//        slice 0.
//  5. Back-to-back: case 1, then A=B=0 x4 with cin=0, out_ready=1
//     -> 8 consecutive cycles of out_valid; second transaction all 0000,
//        cout=0 (no carry leak).
//  6. [CSA_SIGNED_OVF_EN] A=FFFF,FFFF,FFFF,7FFF; B=0001,0,0,0
//     -> last slice 8000, ovf=1, cout=0; with WORDS=1, A=8000, B=8000
//     -> sum 0000, ovf=1, cout=1.

Source files
------------

// File: rtl/csa_wordserial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : csa_wordserial_adder (with helper adderblock16bit)
//  Purpose  : Word-serial multi-precision adder. Operand slices arrive LS
//             first on a valid/ready stream, pass through a 16-bit
//             conditional-sum adder with the running carry, and leave
//             through a single output register together with last/carry-out.
//  Options  : CSA_SIGNED_OVF_EN - adds the registered 'ovf' output
//             (two's-complement overflow of the full-width sum).
//  Revision : 1.0 - initial release
// ============================================================================

// 16-bit conditional-sum adder: every block computes its sum for both
// possible carry-ins, and block pairs are merged over four levels.
module adderblock16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [16:0] sum
);

  function automatic logic [16:0] cond_sum16(input logic [15:0] fa,
                                             input logic [15:0] fb,
                                             input logic        fc);
    logic [15:0] s0, s1, c0, c1;
    logic [15:0] ns0, ns1, nc0, nc1;
    // Level 0: one-bit blocks, sums and carries for carry-in 0 and 1
    s0 = fa ^ fb;
    s1 = ~(fa ^ fb);
    c0 = fa & fb;
    c1 = fa | fb;
    // Levels 1..4: block size 2^k; the low half's carry picks the high half
    for (int k = 1; k <= 4; k++) begin
      ns0 = s0;
      ns1 = s1;
      nc0 = '0;
      nc1 = '0;
      for (int i = 0; i < 16; i++) begin
        if (((i >> (k - 1)) & 1) == 1) begin
          ns0[4'(i)] = c0[4'((i >> k) * 2)] ? s1[4'(i)] : s0[4'(i)];
          ns1[4'(i)] = c1[4'((i >> k) * 2)] ? s1[4'(i)] : s0[4'(i)];
        end
      end
      for (int j = 0; j < (16 >> k); j++) begin
        nc0[4'(j)] = c0[4'(2 * j)] ? c1[4'(2 * j + 1)] : c0[4'(2 * j + 1)];
        nc1[4'(j)] = c1[4'(2 * j)] ? c1[4'(2 * j + 1)] : c0[4'(2 * j + 1)];
      end
      s0 = ns0;
      s1 = ns1;
      c0 = nc0;
      c1 = nc1;
    end
    return fc ? {c1[0], s1} : {c0[0], s0};
  endfunction

  assign sum = cond_sum16(a, b, cin);

endmodule

module csa_wordserial_adder #(
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_word,
  input  logic [15:0] b_word,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum_word,
  output logic        out_last,
  output logic        cout
`ifdef CSA_SIGNED_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int               CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WORDS - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;  // next slice is slice 0
  localparam logic [0:0] S_ACCUM = 1'b1;  // mid-transaction

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             w_accept;
  logic             w_last;
  logic             w_first;
  logic             w_adder_cin;
  logic [16:0]      w_sum;

  // A new slice may enter whenever the output register is empty or draining
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == C_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state: leave IDLE on any accept, return after the final slice
  always_comb begin
    w_state_next = r_state;
    if (w_accept) w_state_next = w_last ? S_IDLE : S_ACCUM;
  end

  // State outputs: slice 0 takes the external carry-in, others the running carry
  always_comb begin
    w_first     = (r_state == S_IDLE);
    w_adder_cin = w_first ? cin : r_carry;
  end

  adderblock16bit u_adder (
    .a   (a_word),
    .b   (b_word),
    .cin (w_adder_cin),
    .sum (w_sum)
  );

  // Output register, slice counter and running carry; everything holds on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum_word  <= '0;
      out_last  <= 1'b0;
      cout      <= 1'b0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      sum_word  <= w_sum[15:0];
      out_last  <= w_last;
      cout      <= w_sum[16];
      r_carry   <= w_sum[16];
      r_cnt     <= w_last ? '0 : r_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CSA_SIGNED_OVF_EN
  // Signed overflow of the full-width add, judged on the most significant slice
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (w_accept) begin
      ovf <= w_last && (a_word[15] == b_word[15]) && (w_sum[15] != a_word[15]);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_csa_wordserial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_wordserial_adder
//  Purpose  : Self-checking bench for csa_wordserial_adder (WORDS=4): vector
//             table, stall / reset / back-to-back sequences, random traffic
//             against a full-width arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csa_wordserial_adder;

  localparam int WORDS = 4;
  localparam int W     = WORDS * 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_word;
  logic [15:0] b_word;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum_word;
  logic        out_last;
  logic        cout;
`ifdef CSA_SIGNED_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int hs_count = 0;
  int hs_first = 0;
  int hs_last  = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [15:0] sum;
    logic        last;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  exp_t expq[$];
  exp_t mon_e;
  vec_t vecs[8];

  csa_wordserial_adder #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_word  (sum_word),
    .out_last  (out_last),
    .cout      (cout)
`ifdef CSA_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Random downstream back-pressure during the random phase
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each output handshake is compared with the oldest expected slice
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got sum_word=%h expected no slice", sum_word);
      end else begin
        mon_e = expq.pop_front();
        check("sum_word", 32'(sum_word), 32'(mon_e.sum));
        check("out_last", 32'(out_last), 32'(mon_e.last));
        if (mon_e.last) check("cout", 32'(cout), 32'(mon_e.cout));
`ifdef CSA_SIGNED_OVF_EN
        check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
        hs_count++;
        if (hs_count == 1) hs_first = cyc;
        hs_last = cyc;
      end
    end
  end

  task automatic push_expected(input logic [W-1:0] sv, input logic co, input logic ov);
    for (int w = 0; w < WORDS; w++) begin
      exp_t e;
      e.sum  = sv[w*16 +: 16];
      e.last = (w == WORDS - 1);
      e.cout = co;
      e.ovf  = (w == WORDS - 1) ? ov : 1'b0;
      expq.push_back(e);
    end
  endtask

  // Reference: one wide addition, then cut into slices
  task automatic push_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    push_expected(s[W-1:0], s[W], (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]));
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send_word(input logic [15:0] a, input logic [15:0] b, input logic c);
    int  n;
    logic acc;
    in_valid = 1'b1;
    a_word   = a;
    b_word   = b;
    cin      = c;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  // cin is randomised on non-first slices: the DUT must ignore it there
  task automatic send_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    for (int w = 0; w < WORDS; w++)
      send_word(a[w*16 +: 16], b[w*16 +: 16], (w == 0) ? c : 1'($urandom));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d slices pending expected 0", name, expq.size());
      expq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    rst = 1'b1; in_valid = 1'b0; a_word = '0; b_word = '0; cin = 1'b0; out_ready = 1'b1;

    //            a                      b                      cin   sum                    cout  ovf
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_00CD, 64'h0000_0000_0000_00FC, 1'b1, 64'h0000_0000_0000_01CA, 1'b0, 1'b0};
    vecs[2] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 1'b1};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
    vecs[6] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b0, 1'b0};
    vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum_word",  32'(sum_word),  32'd0);
    check("reset_out_last",  32'(out_last),  32'd0);
    check("reset_cout",      32'(cout),      32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd1);
`ifdef CSA_SIGNED_OVF_EN
    check("reset_ovf",       32'(ovf),       32'd0);
`endif
    @(posedge clk);
    #1;

    // Vector table, full throughput
    for (int i = 0; i < 8; i++) begin
      push_expected(vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
      send_txn(vecs[i].a, vecs[i].b, vecs[i].cin);
    end
    drain("table");

    // Stall three cycles after the first result of vector 0
    out_ready = 1'b0;
    push_model(vecs[0].a, vecs[0].b, vecs[0].cin);
    send_word(vecs[0].a[15:0], vecs[0].b[15:0], vecs[0].cin);
    in_valid = 1'b1; a_word = vecs[0].a[31:16]; b_word = vecs[0].b[31:16]; cin = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum_word",  32'(sum_word),  32'h0000);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int w = 1; w < WORDS; w++)
      send_word(vecs[0].a[w*16 +: 16], vecs[0].b[w*16 +: 16], 1'($urandom));
    drain("stall");

    // Reset after two slices; the next slice must restart as slice 0
    expq.push_back('{16'h0002, 1'b0, 1'b0, 1'b0});
    send_word(16'h0001, 16'h0001, 1'b0);
    send_word(16'h0001, 16'h0001, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    push_model(64'h1, 64'h1, 1'b1);
    send_txn(64'h1, 64'h1, 1'b1);
    drain("reset");

    // Back-to-back transactions: no bubbles, no carry leak
    hs_count = 0;
    push_model(vecs[0].a, vecs[0].b, vecs[0].cin);
    push_model('0, '0, 1'b0);
    send_txn(vecs[0].a, vecs[0].b, vecs[0].cin);
    send_txn('0, '0, 1'b0);
    drain("back_to_back");
    check("b2b_slices", 32'(hs_count), 32'd8);
    check("b2b_span",   32'(hs_last - hs_first), 32'd7);

    // Random traffic with input gaps and output back-pressure
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ~ra;
        1:       ra[W-1 -: 16] = 16'h7FFF;
        default: ;
      endcase
      push_model(ra, rb, rc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_txn(ra, rb, rc);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
